// File: rtl/huff_pkg.sv
// Shared types and default sizing for the Huffman frequency-counting front end.
// The table entry layout here must agree with huff_encoder.
package huff_pkg;

  localparam int MAX_STRING_LENGTH = 10;
  localparam int MAX_CHAR_COUNT    = 5;
  localparam int FREQ_W            = 4;

  typedef struct packed {
    logic              valid;
    logic [7:0]        ch;
    logic [FREQ_W-1:0] freq;
  } huff_entry_t;

  typedef enum logic [1:0] {
    COLLECT,
    SORT,
    DONE
  } huff_fc_state_e;

  // Invalid entries carry a set MSB so they always order after valid ones.
  function automatic logic [FREQ_W:0] sort_key(input huff_entry_t e);
    return {~e.valid, e.freq};
  endfunction

endpackage

// File: rtl/huff_cmp_swap.sv
// Compare-exchange of two table entries: lo_o gets the smaller key, hi_o the larger.
// Equal keys keep their order, which is what makes the network sort stable.
module huff_cmp_swap
  import huff_pkg::*;
(
  input  huff_entry_t a_i,
  input  huff_entry_t b_i,
  output huff_entry_t lo_o,
  output huff_entry_t hi_o
);

  always_comb begin
    if (sort_key(a_i) > sort_key(b_i)) begin
      lo_o = b_i;
      hi_o = a_i;
    end else begin
      lo_o = a_i;
      hi_o = b_i;
    end
  end

endmodule

// File: rtl/huff_freq_counter.sv
// Builds a unique-character frequency table from a byte stream, stable-sorts it
// ascending by frequency and holds it for huff_encoder until acknowledged.
module huff_freq_counter #(
  parameter int MAX_STRING_LENGTH = huff_pkg::MAX_STRING_LENGTH,
  parameter int MAX_CHAR_COUNT    = huff_pkg::MAX_CHAR_COUNT,
  parameter int FREQ_W            = huff_pkg::FREQ_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [7:0]                             in_char,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [MAX_CHAR_COUNT-1:0][7:0]         character,
  output logic [MAX_CHAR_COUNT-1:0][FREQ_W-1:0]  freq_out,
  output logic [$clog2(MAX_CHAR_COUNT+1)-1:0]    unique_count,
  output logic [FREQ_W-1:0]                      str_len,
  output logic                                   overflow,
  output logic                                   truncated,
  output logic                                   done,
  input  logic                                   out_ack
);

  import huff_pkg::*;

  localparam int UW = $clog2(MAX_CHAR_COUNT + 1);

  huff_fc_state_e                   state_q, state_d;
  huff_entry_t [MAX_CHAR_COUNT-1:0] tbl_q, tbl_d;
  huff_entry_t [MAX_CHAR_COUNT-1:0] pass_tbl;
  huff_entry_t [MAX_CHAR_COUNT-2:0] lo, hi;
  logic [UW-1:0]                    unique_q, unique_d;
  logic [UW-1:0]                    sort_cnt_q, sort_cnt_d;
  logic [FREQ_W-1:0]                str_len_q, str_len_d;
  logic                             overflow_q, overflow_d;
  logic                             truncated_q, truncated_d;
  logic [MAX_CHAR_COUNT-1:0]        hit;

  // One comparator per adjacent pair; the pass parity decides which ones apply.
  for (genvar i = 0; i < MAX_CHAR_COUNT - 1; i++) begin : g_cmp
    huff_cmp_swap u_cmp (
      .a_i  (tbl_q[i]),
      .b_i  (tbl_q[i+1]),
      .lo_o (lo[i]),
      .hi_o (hi[i])
    );
  end

  always_comb begin
    for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
      hit[i] = tbl_q[i].valid && (tbl_q[i].ch == in_char);
    end
  end

  always_comb begin
    pass_tbl = tbl_q;
    for (int i = 0; i < MAX_CHAR_COUNT - 1; i++) begin
      if (i[0] == sort_cnt_q[0]) begin
        pass_tbl[i]   = lo[i];
        pass_tbl[i+1] = hi[i];
      end
    end
  end

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    unique_d    = unique_q;
    sort_cnt_d  = sort_cnt_q;
    str_len_d   = str_len_q;
    overflow_d  = overflow_q;
    truncated_d = truncated_q;

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          str_len_d = str_len_q + 1'b1;
          if (|hit) begin
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
              if (hit[i]) tbl_d[i].freq = tbl_q[i].freq + 1'b1;
            end
          end else if (unique_q < UW'(MAX_CHAR_COUNT)) begin
            for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
              if (UW'(i) == unique_q) begin
                tbl_d[i].valid = 1'b1;
                tbl_d[i].ch    = in_char;
                tbl_d[i].freq  = FREQ_W'(1);
              end
            end
            unique_d = unique_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end

          if (in_last) begin
            state_d    = SORT;
            sort_cnt_d = '0;
          end else if (str_len_q == FREQ_W'(MAX_STRING_LENGTH - 1)) begin
            truncated_d = 1'b1;
            state_d     = SORT;
            sort_cnt_d  = '0;
          end
        end
      end

      // N exchange passes, then one settle cycle so done lands N+1 edges after the last byte.
      SORT: begin
        if (sort_cnt_q == UW'(MAX_CHAR_COUNT)) begin
          state_d = DONE;
        end else begin
          tbl_d      = pass_tbl;
          sort_cnt_d = sort_cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ack) begin
          state_d     = COLLECT;
          tbl_d       = '0;
          unique_d    = '0;
          sort_cnt_d  = '0;
          str_len_d   = '0;
          overflow_d  = 1'b0;
          truncated_d = 1'b0;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      // NOTE: the table drives the outputs directly, so it is cleared on reset like any flag.
      tbl_q       <= '0;
      unique_q    <= '0;
      sort_cnt_q  <= '0;
      str_len_q   <= '0;
      overflow_q  <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      unique_q    <= unique_d;
      sort_cnt_q  <= sort_cnt_d;
      str_len_q   <= str_len_d;
      overflow_q  <= overflow_d;
      truncated_q <= truncated_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
      character[i] = tbl_q[i].ch;
      freq_out[i]  = tbl_q[i].freq;
    end
  end

  assign in_ready     = (state_q == COLLECT);
  assign done         = (state_q == DONE);
  assign unique_count = unique_q;
  assign str_len      = str_len_q;
  assign overflow     = overflow_q;
  assign truncated    = truncated_q;

endmodule

// File: tb/tb_huff_freq_counter.sv
// Directed bench for huff_freq_counter: one task per scenario, hand-computed tables.
module tb_huff_freq_counter;

  localparam int N  = 5;
  localparam int FW = 4;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic [7:0]            in_char;
  logic                  in_last;
  logic                  in_ready;
  logic [N-1:0][7:0]     character;
  logic [N-1:0][FW-1:0]  freq_out;
  logic [2:0]            unique_count;
  logic [FW-1:0]         str_len;
  logic                  overflow;
  logic                  truncated;
  logic                  done;
  logic                  out_ack;

  int checks = 0;
  int errors = 0;

  logic [N-1:0][7:0]    exp_ch;
  logic [N-1:0][FW-1:0] exp_fq;

  huff_freq_counter dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_char      (in_char),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .character    (character),
    .freq_out     (freq_out),
    .unique_count (unique_count),
    .str_len      (str_len),
    .overflow     (overflow),
    .truncated    (truncated),
    .done         (done),
    .out_ack      (out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1ns after an edge and outputs are sampled there too.
  task automatic send_char(input logic [7:0] c, input logic last);
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_string(input string s, input bit last_at_end);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], last_at_end && (i == s.len() - 1));
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (unique_count !== 3'd0) begin errors++; $display("FAIL reset_unique: got %0d exp 0", unique_count); end
    checks++; if (str_len !== 4'd0) begin errors++; $display("FAIL reset_str_len: got %0d exp 0", str_len); end
    checks++; if ({overflow, truncated} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b exp 00", overflow, truncated); end
    checks++; if (character !== '0 || freq_out !== '0) begin errors++; $display("FAIL reset_table: got ch=%h fq=%h exp 0", character, freq_out); end
  endtask

  task automatic test_anu();
    int cyc;
    send_string("anu", 1);
    wait_done(cyc);
    checks++; if (cyc != 6 || done !== 1'b1) begin errors++; $display("FAIL anu_latency: got %0d cycles done=%b exp 6 cycles done=1", cyc, done); end
    exp_ch = {8'h00, 8'h00, "u", "n", "a"};
    exp_fq = {4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    checks++; if (character !== exp_ch) begin errors++; $display("FAIL anu_chars: got %h exp %h", character, exp_ch); end
    checks++; if (freq_out !== exp_fq) begin errors++; $display("FAIL anu_freqs: got %h exp %h", freq_out, exp_fq); end
    checks++; if (unique_count !== 3'd3 || str_len !== 4'd3) begin errors++; $display("FAIL anu_counts: got uniq=%0d len=%0d exp 3/3", unique_count, str_len); end
    checks++; if (overflow !== 1'b0 || truncated !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL anu_flags: got ovf=%b trn=%b rdy=%b exp 0/0/0", overflow, truncated, in_ready); end
    do_ack();
    checks++; if (done !== 1'b0 || in_ready !== 1'b1 || unique_count !== 3'd0 || character !== '0) begin
      errors++; $display("FAIL anu_ack_clear: got done=%b rdy=%b uniq=%0d ch=%h exp 0/1/0/0", done, in_ready, unique_count, character);
    end
  endtask

  task automatic test_anusha();
    int cyc;
    send_string("anusha", 1);
    wait_done(cyc);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL anusha_done: got %b exp 1", done); end
    exp_ch = {"a", "h", "s", "u", "n"};
    exp_fq = {4'd2, 4'd1, 4'd1, 4'd1, 4'd1};
    checks++; if (character !== exp_ch) begin errors++; $display("FAIL anusha_chars: got %h exp %h", character, exp_ch); end
    checks++; if (freq_out !== exp_fq) begin errors++; $display("FAIL anusha_freqs: got %h exp %h", freq_out, exp_fq); end
    checks++; if (unique_count !== 3'd5 || str_len !== 4'd6) begin errors++; $display("FAIL anusha_counts: got uniq=%0d len=%0d exp 5/6", unique_count, str_len); end
    do_ack();
  endtask

  task automatic test_hold_and_ack();
    int cyc;
    send_string("aabb", 1);
    wait_done(cyc);
    exp_ch = {8'h00, 8'h00, 8'h00, "b", "a"};
    exp_fq = {4'd0, 4'd0, 4'd0, 4'd2, 4'd2};
    checks++; if (unique_count !== 3'd2) begin errors++; $display("FAIL aabb_unique: got %0d exp 2", unique_count); end
    out_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (done !== 1'b1 || character !== exp_ch || freq_out !== exp_fq) begin
        errors++; $display("FAIL aabb_hold cycle %0d: got done=%b ch=%h fq=%h exp 1 %h %h", k, done, character, freq_out, exp_ch, exp_fq);
      end
      @(posedge clk); #1;
    end
    do_ack();
    checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL aabb_ack: got done=%b rdy=%b exp 0/1", done, in_ready); end
  endtask

  task automatic test_overflow();
    int cyc;
    send_string("abcdef", 1);
    wait_done(cyc);
    exp_ch = {"e", "d", "c", "b", "a"};
    exp_fq = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    checks++; if (str_len !== 4'd6 || unique_count !== 3'd5) begin errors++; $display("FAIL ovf_counts: got len=%0d uniq=%0d exp 6/5", str_len, unique_count); end
    checks++; if (character !== exp_ch || freq_out !== exp_fq) begin errors++; $display("FAIL ovf_table: got ch=%h fq=%h exp %h %h", character, freq_out, exp_ch, exp_fq); end
    do_ack();
  endtask

  task automatic test_truncate();
    int cyc;
    send_string("aaaaabbbbb", 0);
    checks++; if (truncated !== 1'b1 || in_ready !== 1'b0 || str_len !== 4'd10) begin
      errors++; $display("FAIL trunc_flag: got trn=%b rdy=%b len=%0d exp 1/0/10", truncated, in_ready, str_len);
    end
    in_valid = 1'b1;
    in_char  = "c";
    out_ack  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL trunc_sort_busy: got rdy=%b done=%b exp 0/0", in_ready, done); end
    in_valid = 1'b0;
    out_ack  = 1'b0;
    wait_done(cyc);
    exp_ch = {8'h00, 8'h00, 8'h00, "b", "a"};
    exp_fq = {4'd0, 4'd0, 4'd0, 4'd5, 4'd5};
    checks++; if (done !== 1'b1 || character !== exp_ch || freq_out !== exp_fq) begin
      errors++; $display("FAIL trunc_table: got done=%b ch=%h fq=%h exp 1 %h %h", done, character, freq_out, exp_ch, exp_fq);
    end
    checks++; if (str_len !== 4'd10 || unique_count !== 3'd2 || overflow !== 1'b0) begin
      errors++; $display("FAIL trunc_counts: got len=%0d uniq=%0d ovf=%b exp 10/2/0", str_len, unique_count, overflow);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_sort();
    int cyc;
    send_string("ab", 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || done !== 1'b0 || unique_count !== 3'd0 || str_len !== 4'd0 || character !== '0) begin
      errors++; $display("FAIL midsort_reset: got rdy=%b done=%b uniq=%0d len=%0d ch=%h exp 1/0/0/0/0", in_ready, done, unique_count, str_len, character);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midsort_no_output: got done=%b exp 0", done); end
    send_string("z", 1);
    wait_done(cyc);
    exp_ch = {8'h00, 8'h00, 8'h00, 8'h00, "z"};
    exp_fq = {4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    checks++; if (done !== 1'b1 || character !== exp_ch || freq_out !== exp_fq || unique_count !== 3'd1) begin
      errors++; $display("FAIL midsort_followup: got done=%b ch=%h fq=%h uniq=%0d exp 1 %h %h 1", done, character, freq_out, unique_count, exp_ch, exp_fq);
    end
    do_ack();
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    in_last  = 1'b0;
    out_ack  = 1'b0;
    test_reset();
    test_anu();
    test_anusha();
    test_hold_and_ack();
    test_overflow();
    test_truncate();
    test_reset_mid_sort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
